sign_magnitude_a2_serial_converter: RTL
=======================================

Name: sign_magnitude_a2_serial_converter

Overview:
Sequential back-end converter for the multiplier datapath: accepts the unsigned magnitude product plus its sign bit and returns the signed two's complement result. Negation is bit-serial, LSB first (copy bits up to and including the first 1, then invert the rest), one bit per clock, to keep area minimal. Sits after the sequential multiplier core and drives the final product register. Reports range overflow for the signed WIDTH-bit result.

Parameters:
WIDTH, 16, bit width of magnitude input and two's complement output (≥2)

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-low reset
Start  input  1  request; sampled only when Ready=1
Sign  input  1  1 = negative result required
In_Bits  input  WIDTH  unsigned magnitude
Ready  output  1  1 when IDLE, able to accept Start
Done  output  1  one-cycle pulse; Out_Bits/Overflow valid
Out_Bits  output  WIDTH  two's complement result, held until next accepted Start
Overflow  output  1  result not representable in signed WIDTH bits, held with Out_Bits

Behaviour:
- Reset (reset=0 at clk edge): state=IDLE, Ready=1, Done=0, Out_Bits=0, Overflow=0, internal shift/count regs=0. Applies in any state, aborting a conversion mid-shift with no Done.
- States: IDLE, SHIFT, DONE.
- IDLE: Ready=1. Start=1 at an edge captures In_Bits and Sign, and computes Overflow:
  - Sign=0: Overflow = In_Bits[WIDTH-1].
  - Sign=1: Overflow = (In_Bits > 2^(WIDTH-1)).
  - In_Bits = 2^(WIDTH-1) with Sign=1 is legal and gives 100..0.
- Fast path: Sign=0, or In_Bits=0 (negative zero): IDLE→DONE and Out_Bits=In_Bits. Done is asserted in the cycle after acceptance (latency 1).
- Negative path (Sign=1, In_Bits≠0): IDLE→SHIFT.
  - One bit is processed per cycle, LSB first, via a 1-bit "seen_one" flag and a counter 0..WIDTH-1.
  - Output bit = in_bit while seen_one=0; otherwise ~in_bit. seen_one is set after the first 1 is emitted.
  - After WIDTH SHIFT cycles → DONE. Done is asserted WIDTH+1 cycles after acceptance.
- DONE: Done=1 for exactly one cycle, Ready=0, then →IDLE.
- Out_Bits does not change during SHIFT; it is built in a separate shift register and loaded at the SHIFT→DONE transition.
- Start while Ready=0 is ignored; there is no queueing.
- Start in the same cycle as reset=0: reset wins.
- Back-to-back: Start may be accepted in the first IDLE cycle after DONE, giving a minimum issue interval of 2 cycles (fast path) or WIDTH+2 (negative path).
- Without saturation, Out_Bits on overflow is the low WIDTH bits of the conversion (wrap-around).

Optional Feature:
SATURATE_EN
- Defined: when Overflow=1, the value loaded into Out_Bits is clamped: 0 then all 1s (0x7FFF for WIDTH=16) if Sign=0; 1 then all 0s (0x8000) if Sign=1. Overflow is still reported. Timing and latency are unchanged.
- Undefined: wrap-around result as above; no clamp logic is synthesized.

Test Plan:
All scenarios use WIDTH=16.
1. Reset, then Sign=0, In_Bits=0x0123, Start=1 → Done high 1 cycle later, Out_Bits=0x0123, Overflow=0, Ready high again the next cycle.
2. Sign=1, In_Bits=0x0001 → Done exactly 17 cycles after acceptance, Out_Bits=0xFFFF, Overflow=0. Sign=1, In_Bits=0x00F0 → Out_Bits=0xFF10.
3. Sign=1, In_Bits=0x8000 → Out_Bits=0x8000, Overflow=0. Sign=1, In_Bits=0x8001 → Overflow=1; Out_Bits=0x7FFF without SATURATE_EN, 0x8000 with it.
4. Sign=0, In_Bits=0x9000 → Overflow=1; Out_Bits=0x9000 without SATURATE_EN, 0x7FFF with it. Sign=1, In_Bits=0x0000 → fast path, Out_Bits=0x0000, Overflow=0.
5. Start pulsed with new operands during SHIFT → ignored; original result delivered unchanged. reset=0 at SHIFT cycle 5 → next cycle IDLE, Ready=1, Out_Bits=0, no Done pulse.
6. Back-to-back: negative conversion, then Start in the first IDLE cycle → second conversion accepted. Previous Out_Bits is held until the second DONE.

Source files
------------

// File: rtl/sign_magnitude_a2_serial_converter.sv
// -----------------------------------------------------------------------------
// sign_magnitude_a2_serial_converter
//
// Back-end converter for the sequential multiplier: turns an unsigned
// magnitude plus a sign bit into a signed two's complement WIDTH-bit result.
// Negation is done bit-serially, LSB first, one bit per clock: bits are copied
// up to and including the first 1, and every later bit is inverted.
// Positive operands and negative zero take a one-cycle fast path.
//
// Optional feature macro: SATURATE_EN
//   defined   - an overflowing result is clamped to the most positive value
//               (Sign=0) or the most negative value (Sign=1)
//   undefined - an overflowing result wraps (low WIDTH bits of the conversion)
//
// Ports
//   clk       in   system clock, all logic on the rising edge
//   reset     in   synchronous, active-low reset
//   Start     in   conversion request, sampled only while Ready=1
//   Sign      in   1 = negative result required
//   In_Bits   in   [WIDTH-1:0] unsigned magnitude
//   Ready     out  1 while IDLE, able to accept Start
//   Done      out  one-cycle pulse, Out_Bits/Overflow valid
//   Out_Bits  out  [WIDTH-1:0] two's complement result, held until next result
//   Overflow  out  result not representable in signed WIDTH bits
// -----------------------------------------------------------------------------
module sign_magnitude_a2_serial_converter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Start,
  input  logic             Sign,
  input  logic [WIDTH-1:0] In_Bits,
  output logic             Ready,
  output logic             Done,
  output logic [WIDTH-1:0] Out_Bits,
  output logic             Overflow
);

  localparam int                CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(WIDTH - 1);
  // 100..0: the most negative representable value, also 2^(WIDTH-1).
  localparam logic [WIDTH-1:0]  MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] in_sr;     // magnitude, consumed LSB first
  logic [WIDTH-1:0] out_sr;    // negated bits, shifted in from the MSB side
  logic [CNT_W-1:0] cnt;
  logic             seen_one;
  logic             ovf_q;     // overflow of the conversion in flight

  logic             start_ovf;
  logic             out_bit;
  logic [WIDTH-1:0] neg_result;
  logic [WIDTH-1:0] fast_value;
  logic [WIDTH-1:0] shift_value;

  // Magnitude 2^(WIDTH-1) is still representable when negative.
  assign start_ovf  = Sign ? (In_Bits > MIN_NEG) : In_Bits[WIDTH-1];

  assign out_bit    = seen_one ? ~in_sr[0] : in_sr[0];

  // After the last shift this is the complete negated value; it is what gets
  // loaded into Out_Bits so the output never shows a partial result.
  assign neg_result = {out_bit, out_sr[WIDTH-1:1]};

`ifdef SATURATE_EN
  // The fast path can only overflow with Sign=0 (negative zero never does),
  // and the shift path is always negative, so the clamp direction is implied
  // by the path and no sign register is needed.
  assign fast_value  = start_ovf ? ~MIN_NEG : In_Bits;
  assign shift_value = ovf_q     ? MIN_NEG  : neg_result;
`else
  assign fast_value  = In_Bits;
  assign shift_value = neg_result;
`endif

  // NOTE: all state below uses non-blocking assignments so every register
  // samples the pre-edge values; blocking assignments here would let the
  // shift registers and counter see each other's new values within one edge.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      Ready    <= 1'b1;
      Done     <= 1'b0;
      Out_Bits <= '0;
      Overflow <= 1'b0;
      in_sr    <= '0;
      out_sr   <= '0;
      cnt      <= '0;
      seen_one <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      Done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (Start) begin
            Ready <= 1'b0;
            if (!Sign || (In_Bits == '0)) begin
              state    <= DONE;
              Done     <= 1'b1;
              Out_Bits <= fast_value;
              Overflow <= start_ovf;
            end else begin
              state    <= SHIFT;
              in_sr    <= In_Bits;
              out_sr   <= '0;
              cnt      <= '0;
              seen_one <= 1'b0;
              ovf_q    <= start_ovf;
            end
          end
        end

        SHIFT: begin
          in_sr    <= in_sr >> 1;
          out_sr   <= neg_result;
          seen_one <= seen_one | in_sr[0];
          cnt      <= cnt + CNT_W'(1);
          if (cnt == LAST_BIT) begin
            state    <= DONE;
            Done     <= 1'b1;
            Out_Bits <= shift_value;
            Overflow <= ovf_q;
          end
        end

        DONE: begin
          state <= IDLE;
          Ready <= 1'b1;
        end

        default: begin
          state <= IDLE;
          Ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
